// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a compute engine through a fixed seven-step layer table,
// issuing one start pulse per step and aborting if the engine stays silent too long.
module layer_sequencer #(
  parameter int          STOP_LAYER = 7,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        START,
  input  logic        eng_done,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [2:0]  eng_step,
  output logic [16:0] w_base,
  output logic [7:0]  b_base,
  output logic        src_rom,
  output logic [12:0] src_base,
  output logic [12:0] dst_base,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ADV   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;
  localparam logic [2:0] ABORT = 3'd5;
  localparam logic [2:0] LAST_STEP = (STOP_LAYER > 6) ? 3'd6 : 3'(STOP_LAYER);
  logic [2:0]  state_q, state_d, step_q, step_d;
  logic [23:0] cnt_q, cnt_d, cnt_inc;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  // The count saturates so a huge TIMEOUT can never be skipped past by wrapping.
  assign cnt_inc = (cnt_q == 24'hFFFFFF) ? cnt_q : cnt_q + 24'd1;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = ISSUE;
        step_d  = 3'd0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      ISSUE: begin
        cnt_d   = 24'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (eng_done) state_d = ADV;
        else if (cnt_inc >= TIMEOUT) begin
          state_d = ABORT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ADV: if (step_q == LAST_STEP) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        step_d  = step_q + 3'd1;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 24'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign eng_start = (state_q == ISSUE);
  assign eng_step  = step_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  // Table outputs only change on ADV, so they hold across each start/done window.
  always_comb begin
    eng_op   = 2'd3;
    w_base   = 17'd0;
    b_base   = 8'd0;
    src_rom  = 1'b0;
    src_base = 13'd4704;
    dst_base = 13'd0;
    case (step_q)
      3'd0: begin eng_op = 2'd0; src_rom = 1'b1; src_base = 13'd0; end
      3'd1: begin eng_op = 2'd1; src_base = 13'd0; dst_base = 13'd4704; end
      3'd2: begin eng_op = 2'd0; w_base = 17'd54; b_base = 8'd6; end
      3'd3: begin eng_op = 2'd1; src_base = 13'd0; dst_base = 13'd4704; end
      3'd4: begin eng_op = 2'd2; w_base = 17'd864; b_base = 8'd21; end
      3'd5: begin eng_op = 2'd2; w_base = 17'd98064; b_base = 8'd201; src_base = 13'd0; dst_base = 13'd4704; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: drives two sequencers (full run and STOP_LAYER=1) against a
// timeline-based reference model, with directed scenarios and a randomized phase.
module tb_layer_sequencer;
  localparam int TO = 20;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic eng_done [2] = '{1'b0, 1'b0};
  logic eng_start [2], src_rom [2], busy [2], done [2], err [2];
  logic [1:0]  eng_op   [2];
  logic [2:0]  eng_step [2];
  logic [16:0] w_base   [2];
  logic [7:0]  b_base   [2];
  logic [12:0] src_base [2], dst_base [2];
  int tests = 0, fails = 0, cyc = 0, lat = 5;
  int resp [2] = '{-1, -1};
  int q_op[$], q_w[$], q_dst1[$];
  bit m_run [2], m_done [2], m_err [2];
  int m_step [2], m_issue [2], m_pend [2], m_free [2];
  logic [60:0] act_v, exp_v;
  int exp_op [7] = '{0, 1, 0, 1, 2, 2, 3};
  int exp_w  [7] = '{0, 0, 54, 0, 864, 98064, 0};

  always #5 clk = ~clk;

  layer_sequencer #(.STOP_LAYER(7), .TIMEOUT(24'd20)) u0 (
    .clk(clk), .rst(rst), .START(start), .eng_done(eng_done[0]), .eng_start(eng_start[0]),
    .eng_op(eng_op[0]), .eng_step(eng_step[0]), .w_base(w_base[0]), .b_base(b_base[0]),
    .src_rom(src_rom[0]), .src_base(src_base[0]), .dst_base(dst_base[0]),
    .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]));
  layer_sequencer #(.STOP_LAYER(1), .TIMEOUT(24'd20)) u1 (
    .clk(clk), .rst(rst), .START(start), .eng_done(eng_done[1]), .eng_start(eng_start[1]),
    .eng_op(eng_op[1]), .eng_step(eng_step[1]), .w_base(w_base[1]), .b_base(b_base[1]),
    .src_rom(src_rom[1]), .src_base(src_base[1]), .dst_base(dst_base[1]),
    .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]));

  function automatic logic [53:0] row(input int s);
    case (s)
      0: return {2'd0, 17'd0, 8'd0, 1'b1, 13'd0, 13'd0};
      1: return {2'd1, 17'd0, 8'd0, 1'b0, 13'd0, 13'd4704};
      2: return {2'd0, 17'd54, 8'd6, 1'b0, 13'd4704, 13'd0};
      3: return {2'd1, 17'd0, 8'd0, 1'b0, 13'd0, 13'd4704};
      4: return {2'd2, 17'd864, 8'd21, 1'b0, 13'd4704, 13'd0};
      5: return {2'd2, 17'd98064, 8'd201, 1'b0, 13'd0, 13'd4704};
      default: return {2'd3, 17'd0, 8'd0, 1'b0, 13'd4704, 13'd0};
    endcase
  endfunction

  function automatic int last_of(input int k);
    return (k == 0) ? 6 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_err[k] = 0;
      m_step[k] = 0; m_issue[k] = -100; m_pend[k] = -1; m_free[k] = 0;
    end
  endtask

  // Timeline model: a run issues at known cycles; a completion seen in cycle d
  // issues the next step (or finishes) in cycle d+2; silence for TO wait cycles aborts.
  task automatic model_step();
    if (!rst) model_reset();
    else for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        if (cyc >= m_free[k] && start) begin
          m_run[k] = 1; m_step[k] = 0; m_issue[k] = cyc + 1; m_pend[k] = -1; m_done[k] = 0; m_err[k] = 0;
        end
      end else if (m_pend[k] < 0 && cyc > m_issue[k]) begin
        if (eng_done[k]) m_pend[k] = cyc + 2;
        else if (cyc - m_issue[k] >= TO) begin
          m_run[k] = 0; m_done[k] = 1; m_err[k] = 1; m_free[k] = cyc + 2;
        end
      end
      if (m_run[k] && m_pend[k] == cyc + 1) begin
        m_pend[k] = -1;
        if (m_step[k] == last_of(k)) begin
          m_run[k] = 0; m_done[k] = 1; m_free[k] = cyc + 2;
        end else begin
          m_step[k]++; m_issue[k] = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) begin model_reset(); resp = '{-1, -1}; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    for (int k = 0; k < 2; k++) begin
      eng_done[k] = (resp[k] == cyc);
      if (lat == 0) eng_done[k] = eng_done[k] | ($urandom_range(0, 39) == 0);
      if (eng_start[k]) begin
        if (k == 0) begin q_op.push_back(int'(eng_op[0])); q_w.push_back(int'(w_base[0])); end
        else q_dst1.push_back(int'(dst_base[1]));
        resp[k] = (lat < 0) ? -1 : cyc + ((lat == 0) ? int'($urandom_range(1, 24)) : lat);
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear();
    start = 0; tick(); tick();
    q_op.delete(); q_w.delete(); q_dst1.delete();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy[0] || busy[1]) && n < maxc) begin tick(); n++; end
    chk("run_bound_busy", {busy[0], busy[1]}, 0);
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_pulses"}, q_op.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s_op%0d", tag, i), (i < q_op.size()) ? q_op[i] : -1, exp_op[i]);
      chk($sformatf("%s_w%0d", tag, i), (i < q_w.size()) ? q_w[i] : -1, exp_w[i]);
    end
    chk({tag, "_done"}, done[0], 1);
    chk({tag, "_err"}, err[0], 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        act_v = {eng_start[k], busy[k], done[k], err[k], eng_step[k], eng_op[k], w_base[k], b_base[k],
                 src_rom[k], src_base[k], dst_base[k]};
        exp_v = {m_run[k] && (m_issue[k] == cyc), m_run[k], m_done[k], m_err[k], 3'(m_step[k]), row(m_step[k])};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL cycle_match dut%0d cyc=%0d got=%h required=%h", k, cyc, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    #1 set_rst(0);
    repeat (3) tick();
    chk("reset_busy", busy[0], 0);
    chk("reset_flags", {done[0], err[0], eng_start[0]}, 0);
    chk("reset_step", eng_step[0], 0);
    chk("reset_src_rom", src_rom[0], 1);
    set_rst(1);
    // full run, engine answers 5 cycles after each start
    lat = 5; clear(); pulse_start();
    chk("start_latency", eng_start[0], 1);
    wait_idle(300);
    check_full("full");
    chk("stop1_pulses", q_dst1.size(), 2);
    chk("stop1_dst0", (q_dst1.size() > 0) ? q_dst1[0] : -1, 0);
    chk("stop1_dst1", (q_dst1.size() > 1) ? q_dst1[1] : -1, 4704);
    chk("stop1_done", done[1], 1);
    // stray START during step 3 wait
    clear(); pulse_start();
    n = 0;
    while (!(eng_step[0] == 3 && !eng_start[0]) && n < 300) begin tick(); n++; end
    start = 1; tick(); start = 0;
    chk("busy_start_no_pulse", eng_start[0], 0);
    chk("busy_start_step", eng_step[0], 3);
    wait_idle(300);
    check_full("busy_start");
    // engine never answers
    lat = -1; clear(); pulse_start();
    t0 = cyc; n = 0;
    while (!err[0] && n < 60) begin tick(); n++; end
    chk("timeout_gap", cyc - t0, 21);
    chk("timeout_flags", {done[0], err[0], busy[0]}, 3'b110);
    wait_idle(50);
    // completion lands exactly when the counter reaches TIMEOUT
    lat = TO; clear(); pulse_start();
    wait_idle(400);
    check_full("coincident");
    // reset in the middle of step 4
    lat = 5; clear(); pulse_start();
    n = 0;
    while (!(eng_step[0] == 4 && !eng_start[0]) && n < 300) begin tick(); n++; end
    chk("mid_reached_step4", eng_step[0], 4);
    set_rst(0);
    #1;
    chk("mid_reset_flags", {eng_start[0], busy[0], done[0], err[0]}, 0);
    chk("mid_reset_step", eng_step[0], 0);
    tick(); tick(); set_rst(1); tick(); tick();
    chk("post_reset_idle", busy[0], 0);
    clear(); pulse_start();
    wait_idle(300);
    check_full("restart");
    // START held high across FIN starts another run
    lat = 1; clear(); start = 1;
    n = 0;
    while (q_op.size() < 8 && n < 200) begin tick(); n++; end
    start = 0;
    chk("held_restart_cnt", q_op.size(), 8);
    chk("held_restart_op", (q_op.size() > 7) ? q_op[7] : -1, 0);
    wait_idle(200);
    // randomized traffic, latencies, stray completions and resets
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) set_rst(0); else set_rst(1);
      tick();
    end
    set_rst(1); start = 0; tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
